// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin packet arbiter driving a shared 4:1 data mux; a grant is held for a whole
// packet, released on an accepted last beat or forcibly after MAX_BEATS accepted beats.
module mux_4_1_rr_arbiter #(
    parameter int unsigned W         = 4,
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    input  logic [3:0]   in_last,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic [1:0]   sel,
    output logic         busy,
    output logic         err_overrun
);

    localparam int unsigned CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] LastBeat = CW'(MAX_BEATS - 1);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e         state_q;
    logic [1:0]     ptr_q;
    logic [CW-1:0]  cnt_q;
    logic [1:0]     pick;
    logic           accept;

    // Walk from the farthest offset down so the entry nearest ptr_q wins.
    always_comb begin
        logic [1:0] idx;
        idx  = '0;
        pick = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr_q + 2'(i);
            if (in_valid[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        in_ready  = '0;
        if (state_q == StLocked) begin
            out_valid     = in_valid[sel];
            out_last      = in_last[sel];
            in_ready[sel] = out_ready;
            unique case (sel)
                2'd0: out_data = in_data0;
                2'd1: out_data = in_data1;
                2'd2: out_data = in_data2;
                2'd3: out_data = in_data3;
                default: out_data = '0;
            endcase
        end
    end

    assign accept = out_valid && out_ready;
    assign busy   = (state_q == StLocked);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= 2'd0;
            sel         <= 2'd0;
            cnt_q       <= '0;
            err_overrun <= 1'b0;
        end else begin
            err_overrun <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (|in_valid) begin
                        sel     <= pick;
                        cnt_q   <= '0;
                        state_q <= StLocked;
                    end
                end
                StLocked: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CW'(1);
                        // A last beat landing on the limit is a normal release.
                        if (out_last || cnt_q == LastBeat) begin
                            state_q     <= StIdle;
                            ptr_q       <= sel + 2'd1;
                            err_overrun <= !out_last;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed bench for mux_4_1_rr_arbiter: stimulus queues expected beats, a monitor
// pops and compares every accepted beat.
module tb_mux_4_1_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0] in_last;
    logic [3:0] in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic [1:0] sel;
    logic       busy;
    logic       err_overrun;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;

    mux_4_1_rr_arbiter #(.W(4), .MAX_BEATS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data0   (in_data0),
        .in_data1   (in_data1),
        .in_data2   (in_data2),
        .in_data3   (in_data3),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy),
        .err_overrun(err_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [3:0] d);
        case (idx)
            0: in_data0 = d;
            1: in_data1 = d;
            2: in_data2 = d;
            default: in_data3 = d;
        endcase
    endtask

    task automatic push(input int s, input logic [3:0] d, input logic l);
        beat_t b;
        b.sel  = 2'(s);
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Monitor: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(sel), 32'hFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_sel", 32'(sel), 32'(e.sel));
                chk("beat_data", 32'(out_data), 32'(e.data));
                chk("beat_last", 32'(out_last), 32'(e.last));
                chk("beat_ready", 32'(in_ready), 32'(4'b0001 << e.sel));
            end
        end
    end

    // Continuous valid/ready packet of n beats from idx, starting in IDLE.
    task automatic send_pkt(input int idx, input int n, input bit fin_last,
                            input logic [3:0] others, input bit exp_err);
        logic [3:0] d;
        in_valid  = others | (4'b0001 << idx);
        in_last   = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        chk("pkt_idle_busy", 32'(busy), 0);
        chk("pkt_idle_valid", 32'(out_valid), 0);
        step();
        for (int k = 0; k < n; k++) begin
            d = 4'(idx * 4 + k + 1);
            set_data(idx, d);
            in_last[idx] = fin_last && (k == n - 1);
            push(idx, d, in_last[idx]);
            @(negedge clk);
            chk("pkt_sel", 32'(sel), 32'(idx));
            chk("pkt_busy", 32'(busy), 1);
            chk("pkt_err_early", 32'(err_overrun), 0);
            step();
        end
        in_valid = 4'b0000;
        in_last  = 4'b0000;
        @(negedge clk);
        chk("rel_busy", 32'(busy), 0);
        chk("rel_ready", 32'(in_ready), 0);
        chk("rel_err", 32'(err_overrun), 32'(exp_err));
        step();
        @(negedge clk);
        chk("err_pulse_end", 32'(err_overrun), 0);
        step();
    endtask

    // All four requesters valid with 1-beat packets: 5 grants, 2 cycles each.
    task automatic run_all(input int first);
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, 4'(4'h4 + i));
        for (int j = 0; j < 10; j++) begin
            if (j % 2 == 1) begin
                push((first + j / 2) % 4, 4'(4'h4 + (first + j / 2) % 4), 1'b1);
            end
            @(negedge clk);
            chk("all_busy", 32'(busy), 32'(j % 2));
            step();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        chk("all_end_busy", 32'(busy), 0);
        step();
    endtask

    initial begin
        logic [4:0] rdy_pat;
        int         beat;

        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        in_data0  = 4'h1;
        in_data1  = 4'h2;
        in_data2  = 4'h3;
        in_data3  = 4'h4;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_err", 32'(err_overrun), 0);
        step();
        rst      = 1'b0;
        in_valid = 4'b0000;
        in_last  = 4'b0000;

        // Single beat from requester 2 -> ptr becomes 3.
        send_pkt(2, 1, 1'b1, 4'b0000, 1'b0);
        // Rotation from ptr=3: 3,0,1,2,3 -> ptr becomes 0.
        run_all(3);
        // Requester 0 single beat -> ptr becomes 1.
        send_pkt(0, 1, 1'b1, 4'b0000, 1'b0);

        // Requester 1 three-beat packet with requester 0 also valid, ready toggling.
        in_valid  = 4'b0011;
        in_last   = 4'b0001;
        in_data0  = 4'hC;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_idle_busy", 32'(busy), 0);
        step();
        rdy_pat = 5'b10101;
        beat    = 0;
        for (int j = 0; j < 5; j++) begin
            out_ready = rdy_pat[j];
            if (rdy_pat[j]) begin
                in_data1   = 4'(beat + 1);
                in_last[1] = (beat == 2);
                push(1, 4'(beat + 1), in_last[1]);
                beat++;
            end
            @(negedge clk);
            chk("t3_sel", 32'(sel), 1);
            chk("t3_busy", 32'(busy), 1);
            chk("t3_in_ready", 32'(in_ready), rdy_pat[j] ? 32'h2 : 32'h0);
            step();
        end
        in_valid  = 4'b0001;
        in_last   = 4'b0001;
        out_ready = 1'b1;
        push(0, 4'hC, 1'b1);
        @(negedge clk);
        chk("t3_rel_busy", 32'(busy), 0);
        step();
        @(negedge clk);
        chk("t3_next_sel", 32'(sel), 0);
        step();
        in_valid = 4'b0000;
        in_last  = 4'b0000;
        @(negedge clk);
        chk("t3_end_busy", 32'(busy), 0);
        step();

        // Requester 1 never flags last: forced release after 8 beats -> ptr becomes 2.
        send_pkt(1, 8, 1'b0, 4'b0000, 1'b1);

        // Requester 2 with a 5-cycle valid gap after beat 1; still released on beat 8.
        in_valid  = 4'b1111;
        in_last   = 4'b0000;
        out_ready = 1'b1;
        @(negedge clk);
        chk("gap_idle_busy", 32'(busy), 0);
        step();
        in_data2 = 4'd1;
        push(2, 4'd1, 1'b0);
        @(negedge clk);
        chk("gap_sel", 32'(sel), 2);
        step();
        in_valid = 4'b1011;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("gap_out_valid", 32'(out_valid), 0);
            chk("gap_busy", 32'(busy), 1);
            chk("gap_in_ready", 32'(in_ready), 32'h4);
            step();
        end
        in_valid = 4'b1111;
        for (int k = 2; k <= 8; k++) begin
            in_data2 = 4'(k);
            push(2, 4'(k), 1'b0);
            @(negedge clk);
            chk("gap_resume_sel", 32'(sel), 2);
            chk("gap_resume_busy", 32'(busy), 1);
            chk("gap_resume_err", 32'(err_overrun), 0);
            step();
        end
        in_valid = 4'b0000;
        @(negedge clk);
        chk("gap_rel_busy", 32'(busy), 0);
        chk("gap_rel_err", 32'(err_overrun), 1);
        step();
        @(negedge clk);
        chk("gap_err_end", 32'(err_overrun), 0);
        step();

        // ptr=3: requester 3 wins over 0..2; last on the 8th beat is a clean release.
        send_pkt(3, 8, 1'b1, 4'b0111, 1'b0);

        // Asynchronous reset in the middle of a LOCKED cycle.
        in_valid  = 4'b0010;
        in_last   = 4'b0000;
        in_data1  = 4'h9;
        out_ready = 1'b0;
        step();
        #1;
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_sel", 32'(sel), 1);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #1;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_ready", 32'(in_ready), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_sel", 32'(sel), 0);
        in_valid = 4'b0000;
        step();
        rst = 1'b0;
        // After reset requester 0 leads: 0,1,2,3,0.
        run_all(0);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
